// File: rtl/ham_dec_sched_if.sv
// Bundle between the decoder scheduler, its requesters and the shared serial
// Hamming(7,4) decoder; the scheduler uses the slave modport.
interface ham_dec_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [7*NREQ-1:0] cw_in;
    logic [NREQ-1:0]   gnt;
    logic              dec_datain;
    logic              dec_dvin;
    logic              dec_dvout;
    logic              dec_code;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [6:0]        res_data;
    logic              res_timeout;
    logic              busy;

    modport master (
        output req, cw_in, dec_dvout, dec_code,
        input  gnt, dec_datain, dec_dvin, res_valid, res_id, res_data,
               res_timeout, busy
    );

    modport slave (
        input  req, cw_in, dec_dvout, dec_code,
        output gnt, dec_datain, dec_dvin, res_valid, res_id, res_data,
               res_timeout, busy
    );
endinterface

// File: rtl/ham_dec_sched.sv
// Shares one serial Hamming(7,4) decoder among NREQ requesters.
// Define HAM_DEC_SCHED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ham_dec_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 31
) (
    input logic            clk,
    input logic            reset,
    ham_dec_sched_if.slave bus
);

    localparam int unsigned CW  = 7;
    localparam int unsigned TW  = 8;
    localparam int unsigned BCW = 3;
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        GAP  = 3'd2,
        WAIT = 3'd3,
        RECV = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]   sh_q, sh_d;
    logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [BCW-1:0]  smp_q, smp_d;
    logic [CW-1:0]   col_q, col_d;
    logic [IDW-1:0]  win_id_q, win_id_d;

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            datain_q, datain_d;
    logic            dvin_q, dvin_d;
    logic            res_valid_q, res_valid_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [CW-1:0]   res_data_q, res_data_d;
    logic            res_timeout_q, res_timeout_d;
    logic            busy_q, busy_d;

    // Arbitration: rotate req so the search base sits at bit 0, then pick the lowest set bit.
    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  base;
    logic [IDW-1:0]  k;
    logic [IDW:0]    win_sum;
    logic [IDW-1:0]  win;
    logic            any_req;
    logic [CW-1:0]   cw_sel;
    logic [TW-1:0]   tcnt_inc;

`ifdef HAM_DEC_SCHED_PRIO_EN
    assign rot  = bus.req;
    assign base = '0;
`else
    logic [IDW-1:0] ptr_q;

    assign rot  = NREQ'({bus.req, bus.req} >> ptr_q);
    assign base = ptr_q;

    // Pointer moves past the winner on every grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (state_q == IDLE && any_req) begin
            ptr_q <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
        end
    end
`endif

    assign any_req = |bus.req;

    always_comb begin
        k = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (rot[i]) k = IDW'(i);
        end
    end

    always_comb begin
        win_sum = {1'b0, base} + {1'b0, k};
        if (win_sum >= (IDW+1)'(NREQ)) win_sum = win_sum - (IDW+1)'(NREQ);
        win = win_sum[IDW-1:0];
    end

    assign cw_sel   = CW'(bus.cw_in >> (CW * win));
    assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + TW'(1);

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sh_q          <= '0;
            bit_cnt_q     <= '0;
            tcnt_q        <= '0;
            smp_q         <= '0;
            col_q         <= '0;
            win_id_q      <= '0;
            gnt_q         <= '0;
            datain_q      <= 1'b0;
            dvin_q        <= 1'b1;
            res_valid_q   <= 1'b0;
            res_id_q      <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh_q          <= sh_d;
            bit_cnt_q     <= bit_cnt_d;
            tcnt_q        <= tcnt_d;
            smp_q         <= smp_d;
            col_q         <= col_d;
            win_id_q      <= win_id_d;
            gnt_q         <= gnt_d;
            datain_q      <= datain_d;
            dvin_q        <= dvin_d;
            res_valid_q   <= res_valid_d;
            res_id_q      <= res_id_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            busy_q        <= busy_d;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d       = state_q;
        sh_d          = sh_q;
        bit_cnt_d     = bit_cnt_q;
        tcnt_d        = tcnt_q;
        smp_d         = smp_q;
        col_d         = col_q;
        win_id_d      = win_id_q;
        gnt_d         = '0;
        datain_d      = 1'b0;
        dvin_d        = 1'b1;
        res_valid_d   = 1'b0;
        res_id_d      = res_id_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = SEND;
                    sh_d      = cw_sel;
                    win_id_d  = win;
                    gnt_d     = NREQ'(1) << win;
                    bit_cnt_d = '0;
                    dvin_d    = 1'b0;
                    datain_d  = cw_sel[CW-1];
                end
            end
            SEND: begin
                if (bit_cnt_q == BCW'(CW - 1)) begin
                    state_d = GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    sh_d      = {sh_q[CW-2:0], 1'b0};
                    dvin_d    = 1'b0;
                    datain_d  = sh_q[CW-2];
                end
            end
            GAP: begin
                state_d = WAIT;
                tcnt_d  = '0;
            end
            WAIT: begin
                tcnt_d = tcnt_inc;
                if (!bus.dec_dvout) begin
                    state_d = RECV;
                    col_d   = {{(CW-1){1'b0}}, bus.dec_code};
                    smp_d   = BCW'(1);
                end else if (tcnt_inc >= TO_LIMIT) begin
                    state_d       = DONE;
                    res_valid_d   = 1'b1;
                    res_id_d      = win_id_q;
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                end
            end
            RECV: begin
                tcnt_d = tcnt_inc;
                if (!bus.dec_dvout) begin
                    col_d = {col_q[CW-2:0], bus.dec_code};
                    smp_d = smp_q + BCW'(1);
                    if (smp_q == BCW'(CW - 1)) begin
                        state_d       = DONE;
                        res_valid_d   = 1'b1;
                        res_id_d      = win_id_q;
                        res_data_d    = {col_q[CW-2:0], bus.dec_code};
                        res_timeout_d = 1'b0;
                    end
                end else if (tcnt_inc >= TO_LIMIT) begin
                    state_d       = DONE;
                    res_valid_d   = 1'b1;
                    res_id_d      = win_id_q;
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.gnt         = gnt_q;
    assign bus.dec_datain  = datain_q;
    assign bus.dec_dvin    = dvin_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_id      = res_id_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ham_dec_sched.sv
// Directed, table-driven bench for ham_dec_sched with a behavioural serial
// Hamming(7,4) decoder played by the bench itself.
module tb_ham_dec_sched;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned IDW     = 2;
    localparam int unsigned TIMEOUT = 31;

    logic clk;
    logic reset;

    ham_dec_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus();

    ham_dec_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic [6:0] send;
        logic       fix;    // decoder corrects (1) or echoes (0)
        int         delay;  // idle WAIT cycles before the frame
        int         kind;   // 0 contiguous, 1 split 3/2/4, 2 silent
        logic [6:0] data;
        logic       to;
        logic       drop;
    } vec_t;

    vec_t vecs[9];
    int   n_vec;
    int   n_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural single-error correction; codeword bit i is Hamming position i+1.
    function automatic logic [6:0] ham_fix(input logic [6:0] w);
        logic [2:0] s;
        logic [6:0] r;
        s = 3'd0;
        r = w;
        for (int p = 1; p <= 7; p++) begin
            if (w[p-1]) s = s ^ 3'(p);
        end
        if (s != 3'd0) r[int'(s) - 1] = ~r[int'(s) - 1];
        return r;
    endfunction

    task automatic do_txn(input vec_t v);
        logic [6:0] sent;
        logic [6:0] word;
        logic       ok;
        int         n;
        int         b;
        int         nsteps;
        bus.req = v.req;
        n = 0;
        tick();
        while (bus.gnt == '0 && n < 8) begin
            tick();
            n++;
        end
        chk("gnt", 32'(bus.gnt), 32'(v.gnt));
        if (bus.gnt == '0) return;
        if (v.drop) bus.req = '0;

        ok   = 1'b1;
        sent = '0;
        for (int s = 0; s < 7; s++) begin
            if (bus.dec_dvin !== 1'b0) ok = 1'b0;
            sent = {sent[5:0], bus.dec_datain};
            // dvout noise while the scheduler is not listening
            bus.dec_dvout = 1'b0;
            bus.dec_code  = 1'b1;
            if (s == 1) chk("gnt_pulse", 32'(bus.gnt), 32'h0);
            tick();
        end
        chk("send_dvin", 32'(ok), 32'h1);
        chk("send_bits", 32'(sent), 32'(v.send));
        chk("gap", 32'({bus.dec_dvin, bus.dec_datain, bus.busy}), 32'b101);
        tick();

        word = v.fix ? ham_fix(sent) : sent;
        if (v.kind == 2) begin
            bus.dec_dvout = 1'b1;
            n = 0;
            while (bus.res_valid !== 1'b1 && n < int'(TIMEOUT) + 4) begin
                tick();
                n++;
            end
            chk("timeout_latency", 32'(n), 32'(TIMEOUT));
        end else begin
            for (int d = 0; d < v.delay; d++) begin
                bus.dec_dvout = 1'b1;
                tick();
            end
            b = 6;
            nsteps = (v.kind == 1) ? 9 : 7;
            for (int s = 0; s < nsteps; s++) begin
                if (v.kind == 1 && (s == 3 || s == 4)) begin
                    bus.dec_dvout = 1'b1;
                    bus.dec_code  = ~word[b];
                end else begin
                    bus.dec_dvout = 1'b0;
                    bus.dec_code  = word[b];
                    b--;
                end
                tick();
            end
            bus.dec_dvout = 1'b1;
            chk("res_valid", 32'(bus.res_valid), 32'h1);
        end
        chk("res_id", 32'(bus.res_id), 32'(v.id));
        chk("res_data", 32'(bus.res_data), 32'(v.data));
        chk("res_timeout", 32'(bus.res_timeout), 32'(v.to));
        tick();
        chk("idle_after_done", 32'({bus.res_valid, bus.busy}), 32'h0);
        chk("res_hold", 32'(bus.res_data), 32'(v.data));
    endtask

    task automatic reset_mid_send();
        bus.req = 4'b0001;
        tick();
        chk("rst_pre_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_ctrl", 32'({bus.gnt, bus.dec_dvin, bus.dec_datain, bus.busy}), 32'b0000_1_0_0);
        chk("rst_res", 32'({bus.res_valid, bus.res_id, bus.res_data, bus.res_timeout}), 32'h0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        bus.req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset         = 1'b1;
        bus.req       = '0;
        bus.cw_in     = {7'h6C, 7'h75, 7'h33, 7'h5A};
        bus.dec_dvout = 1'b1;
        bus.dec_code  = 1'b0;

        //          req      gnt      id     send   fix  dly kind data   to    drop
        vecs[0] = '{4'b0001, 4'b0001, 2'd0, 7'h5A, 1'b0, 3, 0, 7'h5A, 1'b0, 1'b1};
        vecs[1] = '{4'b0100, 4'b0100, 2'd2, 7'h75, 1'b1, 1, 0, 7'h55, 1'b0, 1'b1};
        vecs[2] = '{4'b1000, 4'b1000, 2'd3, 7'h6C, 1'b0, 0, 1, 7'h6C, 1'b0, 1'b1};
        vecs[3] = '{4'b0010, 4'b0010, 2'd1, 7'h33, 1'b0, 0, 2, 7'h00, 1'b1, 1'b1};
`ifdef HAM_DEC_SCHED_PRIO_EN
        vecs[4] = '{4'b1111, 4'b0001, 2'd0, 7'h5A, 1'b0, 2, 0, 7'h5A, 1'b0, 1'b0};
        vecs[5] = '{4'b1111, 4'b0001, 2'd0, 7'h5A, 1'b0, 2, 0, 7'h5A, 1'b0, 1'b0};
        vecs[6] = '{4'b1111, 4'b0001, 2'd0, 7'h5A, 1'b0, 2, 0, 7'h5A, 1'b0, 1'b0};
        vecs[7] = '{4'b1111, 4'b0001, 2'd0, 7'h5A, 1'b0, 2, 0, 7'h5A, 1'b0, 1'b0};
        vecs[8] = '{4'b1111, 4'b0001, 2'd0, 7'h5A, 1'b0, 2, 0, 7'h5A, 1'b0, 1'b1};
`else
        vecs[4] = '{4'b1111, 4'b0001, 2'd0, 7'h5A, 1'b0, 2, 0, 7'h5A, 1'b0, 1'b0};
        vecs[5] = '{4'b1111, 4'b0010, 2'd1, 7'h33, 1'b0, 2, 0, 7'h33, 1'b0, 1'b0};
        vecs[6] = '{4'b1111, 4'b0100, 2'd2, 7'h75, 1'b0, 2, 0, 7'h75, 1'b0, 1'b0};
        vecs[7] = '{4'b1111, 4'b1000, 2'd3, 7'h6C, 1'b0, 2, 0, 7'h6C, 1'b0, 1'b0};
        vecs[8] = '{4'b1111, 4'b0001, 2'd0, 7'h5A, 1'b0, 2, 0, 7'h5A, 1'b0, 1'b1};
`endif

        #1;
        chk("reset_ctrl", 32'({bus.gnt, bus.dec_dvin, bus.dec_datain, bus.busy}), 32'b0000_1_0_0);
        chk("reset_res", 32'({bus.res_valid, bus.res_id, bus.res_data, bus.res_timeout}), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            if (i == 4) reset_mid_send();
            do_txn(vecs[i]);
        end

        bus.req = '0;
        tick();
        tick();
        chk("final_idle", 32'({bus.gnt, bus.busy, bus.dec_dvin}), 32'b0000_0_1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
